// File: rtl/rom_stream_reader_if.sv
// Valid/ready word stream with a last marker, as produced by rom_stream_reader.
// The master drives data/valid/last and the slave drives ready.
interface rom_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/rom_stream_reader.sv
// Burst reader for a synchronous single-port ROM: issues contiguous reads and
// buffers the registered read data in a 4-entry FWFT FIFO feeding a valid/ready stream.
module rom_stream_reader #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] q,
  rom_stream_reader_if.master   m
);

  localparam logic [ADDR_WIDTH:0]   LenOne  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   LenZero = '0;
  localparam logic [ADDR_WIDTH-1:0] AddrOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2:0]            FifoCap = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH:0]   issue_left_q;
  logic [ADDR_WIDTH:0]   out_left_q;
  // v0: read issued (raddr holds it); v1: ROM sampled it, q valid this cycle
  logic                  v0_q, v1_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic [2:0]            count_q;

  logic       accept, zero_done, issue_run, last_hs;
  logic       push, pop;
  logic [2:0] occupancy;

  assign push      = v1_q;
  assign pop       = m.m_valid && m.m_ready;
  // Pops this cycle are not credited, keeping the FIFO overflow-free by construction.
  assign occupancy = count_q + {2'b00, v0_q} + {2'b00, v1_q};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start && (length != LenZero)) state_d = StRun;
      StRun:   if (issue_left_q == LenZero) state_d = StDrain;
      StDrain: if (pop && (out_left_q == LenOne)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM decoded controls
  always_comb begin
    accept    = 1'b0;
    zero_done = 1'b0;
    issue_run = 1'b0;
    last_hs   = 1'b0;
    unique case (state_q)
      StIdle: begin
        accept    = start && (length != LenZero);
        zero_done = start && (length == LenZero);
      end
      StRun: begin
        issue_run = (issue_left_q != LenZero) && (occupancy < FifoCap);
      end
      StDrain: begin
        last_hs = pop && (out_left_q == LenOne);
      end
      default: ;
    endcase
  end

  // Read issue, counters and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr        <= '0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      v0_q         <= 1'b0;
      v1_q         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      // Loading start_addr is itself the first issue of the burst.
      if (accept) begin
        raddr        <= start_addr;
        issue_left_q <= length - LenOne;
      end else if (issue_run) begin
        raddr        <= raddr + AddrOne;
        issue_left_q <= issue_left_q - LenOne;
      end

      if (accept) begin
        out_left_q <= length;
      end else if (pop) begin
        out_left_q <= out_left_q - LenOne;
      end

      v0_q <= accept || issue_run;
      v1_q <= v0_q;

      if (accept) begin
        busy <= 1'b1;
      end else if (last_hs) begin
        busy <= 1'b0;
      end
      done <= zero_done || last_hs;
    end
  end

  // Output FIFO storage and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= q;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      count_q <= count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  // Stream outputs come straight from the FIFO head
  always_comb begin
    m.m_valid = (count_q != 3'd0);
    m.m_data  = m.m_valid ? mem_q[rd_ptr_q] : '0;
    m.m_last  = m.m_valid && (out_left_q == LenOne);
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Self-checking bench for rom_stream_reader: behavioural ROM, directed bursts
// and randomized bursts checked against a queue-based expected stream.
module tb_rom_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] start_addr;
  logic [9:0] length;
  logic       busy, done;
  logic [8:0] raddr;
  logic [7:0] q;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_valid, m_last;

  logic [7:0] rom [512];

  int checks   = 0;
  int failures = 0;

  rom_stream_reader_if #(.DATA_WIDTH(8)) sif ();

  assign sif.m_ready = m_ready;
  assign m_data      = sif.m_data;
  assign m_valid     = sif.m_valid;
  assign m_last      = sif.m_last;

  rom_stream_reader #(
    .ADDR_WIDTH(9),
    .DATA_WIDTH(8),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_addr(start_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .raddr     (raddr),
    .q         (q),
    .m         (sif)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: samples raddr on the rising edge
  always @(posedge clk) q <= rom[raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready always 1; mode 1: toggle with a 10-cycle stall; mode 2: random ready
  task automatic burst(input logic [8:0] sa, input int len, input int mode, input bit inject);
    logic [7:0] expd [$];
    int         t, got, issued;
    logic [8:0] prev_raddr;
    logic       prev_stall;
    logic [7:0] prev_data;
    bit         first_seen;
    for (int k = 0; k < len; k++) expd.push_back(rom[(int'(sa) + k) % 512]);
    @(negedge clk);
    start      = 1'b1;
    start_addr = sa;
    length     = 10'(len);
    m_ready    = (mode == 0);
    @(negedge clk);
    start      = 1'b0;
    start_addr = sa + 9'd77;
    length     = 10'd7;
    t          = 0;
    got        = 0;
    issued     = 1;
    prev_raddr = sa;
    prev_stall = 1'b0;
    prev_data  = '0;
    first_seen = 1'b0;
    forever begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (t >= 6 && t < 16) ? 1'b0 : t[0];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      start = inject && (t == 3);
      if (got == len) begin
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("valid_after", {31'd0, m_valid}, 32'd0);
        if (mode == 0) chk("done_cycle", t, len + 2);
        break;
      end
      chk("done_low", {31'd0, done}, 32'd0);
      chk("busy_high", {31'd0, busy}, 32'd1);
      if (raddr !== prev_raddr) issued++;
      prev_raddr = raddr;
      chk("outstanding_le4", {31'd0, (issued - got) <= 4}, 32'd1);
      if (mode == 0)
        chk("raddr_seq", {23'd0, raddr},
            (t < len) ? (int'(sa) + t) % 512 : (int'(sa) + len - 1) % 512);
      if (prev_stall) begin
        chk("stall_valid", {31'd0, m_valid}, 32'd1);
        chk("stall_data", {24'd0, m_data}, {24'd0, prev_data});
      end
      if (m_valid && !first_seen) begin
        first_seen = 1'b1;
        if (mode == 0) chk("first_valid_lat", t, 2);
      end
      chk("last", {31'd0, m_last}, {31'd0, m_valid && (got == len - 1)});
      if (m_valid && m_ready) begin
        chk("data", {24'd0, m_data}, {24'd0, expd[got]});
        got++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (t > 3 * len + 60) begin
        chk("timeout_words", got, len);
        break;
      end
      @(negedge clk);
      t++;
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 8'(i);
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    length     = '0;
    m_ready    = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_raddr", {23'd0, raddr}, 32'd0);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_last", {31'd0, m_last}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    burst(9'h010, 4, 0, 1'b0);
    burst(9'h1FE, 4, 0, 1'b0);
    burst(9'h030, 16, 1, 1'b0);

    // Zero-length command completes immediately without data
    @(negedge clk);
    start      = 1'b1;
    start_addr = 9'h005;
    length     = 10'd0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    chk("zero_valid", {31'd0, m_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("zero_done_off", {31'd0, done}, 32'd0);
      chk("zero_valid_off", {31'd0, m_valid}, 32'd0);
      chk("zero_busy_off", {31'd0, busy}, 32'd0);
    end

    burst(9'h050, 6, 0, 1'b1);

    // Asynchronous reset with two reads in flight
    @(negedge clk);
    start      = 1'b1;
    start_addr = 9'h040;
    length     = 10'd8;
    m_ready    = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_valid", {31'd0, m_valid}, 32'd0);
    chk("arst_last", {31'd0, m_last}, 32'd0);
    chk("arst_data", {24'd0, m_data}, 32'd0);
    chk("arst_raddr", {23'd0, raddr}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_stale", {31'd0, m_valid}, 32'd0);
    end
    burst(9'h020, 2, 0, 1'b0);

    burst(9'h100, 512, 0, 1'b0);

    // Randomized bursts over random ROM contents
    for (int i = 0; i < 512; i++) rom[i] = 8'($urandom);
    for (int n = 0; n < 10; n++) begin
      burst(9'($urandom), int'($urandom_range(1, 48)), (n % 3 == 0) ? 0 : 2, n[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
